axi_lite_master: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/axi_lite_if.sv | 32 +++
 rtl/axi_lite_master.sv | 149 ++++++++++++++
 tb/tb_axi_lite_master.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state type.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    RESP
  } mst_state_e;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R) with master and slave views.
interface axi_lite_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: converts a single-beat CPU request/response port into
// serialized AXI4-Lite read and write transactions, one outstanding at a time.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  axi_lite_if.master  m
);

  mst_state_e  state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        aw_hs, w_hs;
  logic        unused_resp_lsb;

  // Only resp[1] distinguishes error from success.
  assign unused_resp_lsb = ^{m.bresp[0], m.rresp[0]};

  // State and transaction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic and state-decoded outputs (no req_* to AXI valid path).
  always_comb begin
    state_d    = state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    m.awvalid  = 1'b0;
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    m.awaddr   = addr_q;
    m.araddr   = addr_q;
    m.wdata    = wdata_q;
    m.wstrb    = wstrb_q;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          rdata_d = '0;
          err_d   = 1'b0;
          if (ALIGN_CHECK && (req_addr[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_wen) begin
            state_d = WR_REQ;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        m.arvalid = 1'b1;
        if (m.arready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        m.rready = 1'b1;
        if (m.rvalid) begin
          rdata_d = m.rdata;
          err_d   = m.rresp[1];
          state_d = RESP;
        end
      end
      WR_REQ: begin
        m.awvalid = !aw_done_q;
        m.wvalid  = !w_done_q;
        aw_hs     = !aw_done_q && m.awready;
        w_hs      = !w_done_q && m.wready;
        // Completion counts handshakes landing in this same cycle.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_WAIT;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
      WR_WAIT: begin
        m.bready = 1'b1;
        if (m.bvalid) begin
          err_d   = m.bresp[1];
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master with a behavioural AXI4-Lite slave
// holding a small RAM and a CLINT-style mtime register pair.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam logic [31:0] CLINT_LO = 32'h0a00_0048;
  localparam logic [31:0] CLINT_HI = 32'h0a00_004c;
  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] UNMAPPED = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  axi_lite_if bus();

  axi_lite_master #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m(bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // CLINT mtime: posedges since reset release; also the bench time stamp.
  logic [31:0] mtime;
  always @(posedge clk) begin
    if (reset) mtime <= '0;
    else       mtime <= mtime + 32'd1;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    logic        abs_lat;
    logic [31:0] stamp;
  } exp_t;

  exp_t sb[$];

  logic [31:0] slave_mem [64];
  logic [31:0] mem_model [64];

  int unsigned aw_stall, w_stall, ar_stall, r_lat, b_lat;
  int unsigned aw_cnt, w_cnt, ar_cnt;
  int unsigned aw_hs_n, w_hs_n, ar_hs_n, b_hs_n, r_hs_n, valid_seen;
  bit          rand_mode, r_hold;
  logic [31:0] aw_stamp, w_stamp, last_hs_stamp;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endfunction

  // Reference model: expected response from the address map and request alone.
  function automatic exp_t model(input logic wen, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    logic [31:0] w;
    e = '0;
    if (a[1:0] != 2'b00) begin
      e.err = 1'b1;
      e.mis = 1'b1;
      return e;
    end
    if (a[31:8] == 24'h800000) begin
      if (wen) begin
        w = mem_model[a[7:2]];
        for (int unsigned b = 0; b < 4; b++)
          if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
        mem_model[a[7:2]] = w;
      end else begin
        e.rdata = mem_model[a[7:2]];
      end
    end else if (a == CLINT_LO || a == CLINT_HI) begin
      e.err = wen;
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic void slave_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    d = '0;
    r = RESP_OKAY;
    if (a[31:8] == 24'h800000) d = slave_mem[a[7:2]];
    else if (a == CLINT_LO)    d = mtime;
    else if (a != CLINT_HI)    r = RESP_DECERR;
  endfunction

  function automatic logic [1:0] slave_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[31:8] == 24'h800000) begin
      for (int unsigned b = 0; b < 4; b++)
        if (s[b]) slave_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
      return RESP_OKAY;
    end
    if (a == CLINT_LO || a == CLINT_HI) return RESP_SLVERR;
    return RESP_DECERR;
  endfunction

  // Behavioural slave: sample at negedge, respond #1 after posedge.
  initial begin : slave
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, rst_s;
    logic [31:0] awaddr_s, wdata_s, araddr_s, wr_addr, wr_data, rd_addr, d;
    logic [3:0]  wstrb_s, wr_strb;
    logic [1:0]  rsp;
    bit          have_aw, have_w, rd_pend, wr_pend;
    int unsigned r_cnt, b_cnt;
    have_aw = 0; have_w = 0; rd_pend = 0; wr_pend = 0; r_cnt = 0; b_cnt = 0;
    wr_addr = '0; wr_data = '0; wr_strb = '0; rd_addr = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = '0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    forever begin
      @(negedge clk);
      rst_s    = reset;
      aw_hs    = bus.awvalid && bus.awready;
      w_hs     = bus.wvalid && bus.wready;
      ar_hs    = bus.arvalid && bus.arready;
      b_hs     = bus.bvalid && bus.bready;
      r_hs     = bus.rvalid && bus.rready;
      awaddr_s = bus.awaddr;
      wdata_s  = bus.wdata;
      wstrb_s  = bus.wstrb;
      araddr_s = bus.araddr;
      if (bus.awvalid || bus.wvalid || bus.arvalid) valid_seen++;
      if (bus.awvalid && !bus.awready) aw_cnt++;
      if (bus.wvalid && !bus.wready) w_cnt++;
      if (bus.arvalid && !bus.arready) ar_cnt++;
      if (aw_hs) aw_stamp = mtime;
      if (w_hs) w_stamp = mtime;
      if (b_hs || r_hs) last_hs_stamp = mtime;
      @(posedge clk);
      #1;
      if (rst_s) begin
        have_aw = 0; have_w = 0; rd_pend = 0; wr_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        bus.bvalid = 1'b0;
        bus.rvalid = 1'b0;
      end else begin
        if (aw_hs) begin
          have_aw = 1; wr_addr = awaddr_s; aw_cnt = 0; aw_hs_n++;
          if (rand_mode) aw_stall = $urandom_range(0, 3);
        end
        if (w_hs) begin
          have_w = 1; wr_data = wdata_s; wr_strb = wstrb_s; w_cnt = 0; w_hs_n++;
          if (rand_mode) w_stall = $urandom_range(0, 3);
        end
        if (have_aw && have_w) begin
          bus.bresp = slave_write(wr_addr, wr_data, wr_strb);
          have_aw = 0; have_w = 0; wr_pend = 1; b_cnt = b_lat;
        end
        if (b_hs) begin
          bus.bvalid = 1'b0; b_hs_n++;
          if (rand_mode) b_lat = $urandom_range(0, 3);
        end
        if (wr_pend && !bus.bvalid) begin
          if (b_cnt == 0) begin bus.bvalid = 1'b1; wr_pend = 0; end
          else b_cnt--;
        end
        if (ar_hs) begin
          rd_pend = 1; rd_addr = araddr_s; r_cnt = r_lat; ar_cnt = 0; ar_hs_n++;
          if (rand_mode) ar_stall = $urandom_range(0, 3);
        end
        if (r_hs) begin
          bus.rvalid = 1'b0; r_hs_n++;
          if (rand_mode) r_lat = $urandom_range(0, 3);
        end
        if (rd_pend && !r_hold && !bus.rvalid) begin
          if (r_cnt == 0) begin
            slave_read(rd_addr, d, rsp);
            bus.rdata = d; bus.rresp = rsp; bus.rvalid = 1'b1; rd_pend = 0;
          end else r_cnt--;
        end
      end
      bus.awready = (aw_cnt >= aw_stall);
      bus.wready  = (w_cnt >= w_stall);
      bus.arready = (ar_cnt >= ar_stall);
    end
  end

  // Scoreboard monitor: every resp_valid pops one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_resp: resp_valid=1 with rdata 0x%08h err %0b, expected no response", resp_rdata, resp_err);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          if (e.abs_lat) check("resp_latency", mtime, e.stamp);
          else           check("resp_after_hs", mtime, last_hs_stamp + 32'd1);
        end
      end
    end
  end

  // Channel stability: a pending valid must stay up with its payload unchanged.
  initial begin : proto
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rst;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    logic [3:0]  p_wstrb;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rst = 1;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!p_rst) begin
        if (p_awv && !p_awr) begin
          check("awvalid_held", 32'(bus.awvalid), 32'd1);
          check("awaddr_stable", bus.awaddr, p_awaddr);
        end
        if (p_wv && !p_wr) begin
          check("wvalid_held", 32'(bus.wvalid), 32'd1);
          check("wdata_stable", bus.wdata, p_wdata);
          check("wstrb_stable", 32'(bus.wstrb), 32'(p_wstrb));
        end
        if (p_arv && !p_arr) begin
          check("arvalid_held", 32'(bus.arvalid), 32'd1);
          check("araddr_stable", bus.araddr, p_araddr);
        end
      end
      p_rst = reset;
      p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
      p_wv = bus.wvalid; p_wr = bus.wready; p_wdata = bus.wdata; p_wstrb = bus.wstrb;
      p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
    end
  end

  task automatic issue(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit abs_lat);
    exp_t e;
    int unsigned n;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wstrb = ws;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL req_accept: req_ready=0 for 100 cycles, expected 1");
    end else begin
      e = model(wen, a, wd, ws);
      if (!wen && a == CLINT_LO) e.rdata = mtime + 32'd2;
      e.stamp   = mtime + (e.mis ? 32'd1 : 32'd3);
      e.abs_lat = abs_lat || e.mis;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : main
    int unsigned h0, a0, w0, b0, v0, n;
    logic [31:0] addr;
    logic        wen;
    for (int i = 0; i < 64; i++) begin
      slave_mem[i] = $urandom;
      mem_model[i] = slave_mem[i];
    end
    aw_stall = 0; w_stall = 0; ar_stall = 0; r_lat = 0; b_lat = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0; b_hs_n = 0; r_hs_n = 0; valid_seen = 0;
    rand_mode = 0; r_hold = 0;
    aw_stamp = '0; w_stamp = '0; last_hs_stamp = '0;
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, resp_valid, resp_err}), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Zero-wait slave: CLINT reads back to back, then high word.
    issue(1'b0, CLINT_LO, '0, '0, 1'b1);
    check("arvalid_T1", 32'(bus.arvalid), 32'd1);
    issue(1'b0, CLINT_LO, '0, '0, 1'b1);
    issue(1'b0, CLINT_HI, '0, '0, 1'b1);
    drain();

    // CLINT write is refused with SLVERR.
    a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    issue(1'b1, CLINT_LO, 32'hdead_beef, 4'hf, 1'b1);
    drain();
    check("clint_wr_aw_count", aw_hs_n - a0, 32'd1);
    check("clint_wr_w_count", w_hs_n - w0, 32'd1);
    check("clint_wr_b_count", b_hs_n - b0, 32'd1);

    // Misaligned read never reaches the bus.
    v0 = valid_seen; h0 = ar_hs_n;
    issue(1'b0, 32'h0a00_0049, '0, '0, 1'b1);
    drain();
    check("misaligned_no_valid", valid_seen - v0, 32'd0);
    check("misaligned_no_ar", ar_hs_n - h0, 32'd0);

    // AW held off three cycles, W immediate; then the reverse.
    aw_stall = 3; w_stall = 0;
    a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    issue(1'b1, MEM_BASE + 32'h10, $urandom, 4'b1011, 1'b0);
    drain();
    check("w_before_aw", 32'(w_stamp < aw_stamp), 32'd1);
    check("stall_aw_b_count", b_hs_n - b0, 32'd1);
    aw_stall = 0; w_stall = 3;
    b0 = b_hs_n;
    issue(1'b1, MEM_BASE + 32'h14, $urandom, 4'b0110, 1'b0);
    drain();
    check("aw_before_w", 32'(aw_stamp < w_stamp), 32'd1);
    check("stall_w_b_count", b_hs_n - b0, 32'd1);
    check("stall_hs_counts", (aw_hs_n - a0) + (w_hs_n - w0), 32'd4);
    w_stall = 0;
    issue(1'b0, MEM_BASE + 32'h10, '0, '0, 1'b1);
    issue(1'b0, MEM_BASE + 32'h14, '0, '0, 1'b1);
    drain();

    // Reset while waiting on R with rvalid held low.
    r_hold = 1;
    issue(1'b0, MEM_BASE + 32'h4, '0, '0, 1'b0);
    n = 0;
    while (bus.rready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_rd_wait", 32'(bus.rready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    sb.delete();
    @(negedge clk);
    check("midrst_outputs", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, resp_valid}), 32'd0);
    r_hold = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("postrst_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic against a slave with random stalls and latencies.
    rand_mode = 1;
    aw_stall = $urandom_range(0, 3); w_stall = $urandom_range(0, 3);
    ar_stall = $urandom_range(0, 3); r_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
    for (int i = 0; i < 150; i++) begin
      wen  = 1'($urandom_range(0, 1));
      addr = MEM_BASE + 32'($urandom_range(0, 63)) * 32'd4;
      case ($urandom_range(0, 9))
        6:       addr = CLINT_HI;
        7:       begin addr = CLINT_LO; wen = 1'b1; end
        8:       addr = UNMAPPED + 32'($urandom_range(0, 255)) * 32'd4;
        9:       addr = addr + 32'($urandom_range(1, 3));
        default: ;
      endcase
      issue(wen, addr, $urandom, 4'($urandom_range(0, 15)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
